// File: rtl/c17_bist_pkg.sv
// Shared types and helpers for the C17 BIST engine: FSM states, LFSR step and MISR step.
// Build option C17_BIST_ALLZERO_EN (see c17_bist_engine) does not change anything in this package.
package c17_bist_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int LFSR_W     = 5;
    localparam int RESP_W     = 2;
    localparam int MISR_MAX_W = 32;

    // x^5 + x^3 + 1, maximal length (period 31)
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] p);
        return {p[3:0], p[4] ^ p[2]};
    endfunction

    // MISR step on a width-w signature held in the low bits of a wide vector
    function automatic logic [MISR_MAX_W-1:0] misr_next(input logic [MISR_MAX_W-1:0] sig,
                                                       input logic [RESP_W-1:0]     resp,
                                                       input logic [MISR_MAX_W-1:0] poly,
                                                       input int                    w);
        logic [MISR_MAX_W-1:0] ones;
        logic [MISR_MAX_W-1:0] mask;
        logic [MISR_MAX_W-1:0] fb;
        ones = '1;
        mask = ones >> (MISR_MAX_W - w);
        fb   = sig[5'(w - 1)] ? poly : '0;
        return ({sig[MISR_MAX_W-2:0], 1'b0} ^ fb ^ MISR_MAX_W'(resp)) & mask;
    endfunction

endpackage

// File: rtl/c17_bist_misr.sv
// Multiple-input signature register compacting the two C17 outputs.
// clr reloads the seed and wins over en.
module c17_bist_misr
    import c17_bist_pkg::*;
#(
    parameter int                MISR_W    = 8,
    parameter logic [MISR_W-1:0] MISR_POLY = 8'h1D,
    parameter logic [MISR_W-1:0] MISR_SEED = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [RESP_W-1:0] resp,
    output logic [MISR_W-1:0] sig
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= MISR_SEED;
        end else if (clr) begin
            sig <= MISR_SEED;
        end else if (en) begin
            sig <= MISR_W'(misr_next(MISR_MAX_W'(sig), resp, MISR_MAX_W'(MISR_POLY), MISR_W));
        end
    end

endmodule

// File: rtl/c17_bist_engine.sv
// BIST engine for the C17 CUT: LFSR pattern source, MISR response compactor, start/done handshake.
// Define C17_BIST_ALLZERO_EN to append the all-zero pattern after the LFSR sequence.
module c17_bist_engine
    import c17_bist_pkg::*;
#(
    parameter int                NUM_PATTERNS = 31,
    parameter logic [LFSR_W-1:0] LFSR_SEED    = 5'b00001,
    parameter int                MISR_W       = 8,
    parameter logic [MISR_W-1:0] MISR_POLY    = 8'h1D,
    parameter logic [MISR_W-1:0] MISR_SEED    = '0,
    parameter logic [MISR_W-1:0] GOLDEN_SIG   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    output logic [LFSR_W-1:0] pat_o,
    input  logic [RESP_W-1:0] resp_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [MISR_W-1:0] sig_o
);

`ifdef C17_BIST_ALLZERO_EN
    localparam int LAST_CNT = NUM_PATTERNS + 1;
`else
    localparam int LAST_CNT = NUM_PATTERNS;
`endif

    state_t            state_q, state_d;
    logic [LFSR_W-1:0] pat_q, pat_d;
    logic [5:0]        cnt_q, cnt_d;
    logic              misr_clr, misr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
        end
    end

    // The edge that sees the final count only captures; the pattern holds through DRAIN.
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        cnt_d    = cnt_q;
        misr_clr = 1'b0;
        misr_en  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d  = RUN;
                    pat_d    = LFSR_SEED;
                    cnt_d    = 6'd1;
                    misr_clr = 1'b1;
                end
            end
            RUN: begin
                misr_en = 1'b1;
                if (cnt_q == 6'(LAST_CNT)) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + 6'd1;
`ifdef C17_BIST_ALLZERO_EN
                    pat_d = (cnt_q == 6'(NUM_PATTERNS)) ? '0 : lfsr_next(pat_q);
`else
                    pat_d = lfsr_next(pat_q);
`endif
                end
            end
            DRAIN: begin
                misr_en = 1'b1;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    c17_bist_misr #(
        .MISR_W    (MISR_W),
        .MISR_POLY (MISR_POLY),
        .MISR_SEED (MISR_SEED)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (misr_clr),
        .en    (misr_en),
        .resp  (resp_i),
        .sig   (sig_o)
    );

    assign pat_o  = pat_q;
    assign busy_o = (state_q == RUN) || (state_q == DRAIN);
    assign done_o = (state_q == DONE);
    assign pass_o = (state_q == DONE) && (sig_o == GOLDEN_SIG);

endmodule

// File: tb/tb_c17_bist_engine.sv
// Directed bench for c17_bist_engine: pattern scoreboard, signature reference model, C17 CUT model.
// Honours C17_BIST_ALLZERO_EN in the same way as the design build.
module tb_c17_bist_engine;

    localparam int N = 31;
`ifdef C17_BIST_ALLZERO_EN
    localparam int L = N + 1;
`else
    localparam int L = N;
`endif
    localparam int D = L + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i;
    logic [1:0] resp_i;
    logic [4:0] pat_o, g1_pat_o;
    logic       busy_o, done_o, pass_o;
    logic       g1_busy_o, g1_done_o, g1_pass_o;
    logic [7:0] sig_o, g1_sig_o;

    int         checks = 0;
    int         failures = 0;
    int         respMode = 0;
    logic [1:0] forcedResp = 2'b00;
    logic [4:0] pats [0:32];
    logic [4:0] firstFive [0:4];

    c17_bist_engine u_dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .pat_o(pat_o), .resp_i(resp_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .sig_o(sig_o)
    );

    c17_bist_engine #(.GOLDEN_SIG(8'h01)) u_dut_g1 (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .pat_o(g1_pat_o), .resp_i(resp_i),
        .busy_o(g1_busy_o), .done_o(g1_done_o), .pass_o(g1_pass_o), .sig_o(g1_sig_o)
    );

    always #5 clk = ~clk;

    // C17 netlist: G1,G2,G3,G6,G7 of the classic c17 mapped onto pat_o[0..4]
    function automatic logic [1:0] cutEval(input logic [4:0] p);
        logic n10, n11, n16, n19;
        n10 = ~(p[0] & p[2]);
        n11 = ~(p[2] & p[3]);
        n16 = ~(p[1] & n11);
        n19 = ~(n11 & p[4]);
        return {~(n16 & n19), ~(n10 & n16)};
    endfunction

    function automatic logic [7:0] misrStep(input logic [7:0] s, input logic [1:0] r);
        return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ {6'b0, r};
    endfunction

    always_comb resp_i = (respMode == 2) ? cutEval(pat_o) : forcedResp;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input int mode, input logic [1:0] fr);
        start_i    = start;
        respMode   = mode;
        forcedResp = fr;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_pat"}, pat_o, 0);
        checkOutput({tag, "_busy"}, busy_o, 0);
        checkOutput({tag, "_done"}, done_o, 0);
        checkOutput({tag, "_pass"}, pass_o, 0);
        checkOutput({tag, "_sig"}, sig_o, 0);
    endtask

    // mode 0: resp tied 00; mode 1: 01 on first capture only; mode 2: CUT connected
    task automatic doRun(input int mode, input int pokeAt, input int abortAt);
        logic [4:0] expPatQ [$];
        logic [4:0] expPat;
        logic [7:0] modelSig;
        logic [1:0] r;
        logic [4:0] p;
        logic [1:0] fr;
        modelSig = 8'h00;
        for (int e = 1; e <= D; e++) begin
            p = pats[(e - 1 < L) ? e - 1 : L - 1];
            if (mode == 2)                  r = cutEval(p);
            else if (mode == 1 && e == 1)   r = 2'b01;
            else                            r = 2'b00;
            modelSig = misrStep(modelSig, r);
        end
        fr = (mode == 1) ? 2'b01 : 2'b00;
        applyStimulus(1'b1, mode, fr);
        for (int e = 0; e <= D; e++) expPatQ.push_back(pats[(e < L) ? e : L - 1]);
        @(posedge clk); #1;
        for (int e = 0; e <= D; e++) begin
            if (e > 0) begin
                @(posedge clk); #1;
            end
            start_i = (e == pokeAt);
            if (mode == 1 && e == 1) begin
                checkOutput("sig_first_capture", sig_o, 32'h01);
                forcedResp = 2'b00;
            end
            if (expPatQ.size() == 0) begin
                checkOutput("scoreboard_empty", 1, 0);
            end else begin
                expPat = expPatQ.pop_front();
                checkOutput("pat", pat_o, expPat);
            end
            if (e < 5) checkOutput("pat_first_five", pat_o, firstFive[e]);
            checkOutput("busy", busy_o, (e < D) ? 1 : 0);
            checkOutput("done", done_o, (e == D) ? 1 : 0);
            if (e == abortAt) begin
                #2 rst_n = 1'b0;
                #1 checkResetState("abort");
                @(posedge clk); #1;
                checkResetState("abort_hold");
                rst_n = 1'b1;
                return;
            end
        end
        checkOutput("final_sig", sig_o, modelSig);
        checkOutput("pass_golden0", pass_o, (modelSig == 8'h00) ? 1 : 0);
        checkOutput("g1_done", g1_done_o, 1);
        checkOutput("g1_pass_golden1", g1_pass_o, (modelSig == 8'h01) ? 1 : 0);
        @(posedge clk); #1;
        checkOutput("done_level", done_o, 1);
        checkOutput("sig_frozen", sig_o, modelSig);
        checkOutput("pat_hold", pat_o, pats[L - 1]);
    endtask

    initial begin
        firstFive[0] = 5'h01; firstFive[1] = 5'h02; firstFive[2] = 5'h04;
        firstFive[3] = 5'h09; firstFive[4] = 5'h12;
        pats[0] = 5'h01;
        for (int i = 1; i < 33; i++) pats[i] = {pats[i-1][3:0], pats[i-1][4] ^ pats[i-1][2]};
`ifdef C17_BIST_ALLZERO_EN
        pats[N] = 5'h00;
`endif

        rst_n = 1'b0;
        applyStimulus(1'b0, 0, 2'b00);
        repeat (3) @(posedge clk);
        #1 checkResetState("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle_busy", busy_o, 0);

        $display("[TB] run: responses tied low");
        doRun(0, -1, -1);
        $display("[TB] run: single 01 response, start poke at count 10");
        doRun(1, 9, -1);
        $display("[TB] run: CUT connected, reset at count 20");
        doRun(2, -1, 19);
        $display("[TB] run: CUT connected, full sequence after reset");
        doRun(2, -1, -1);
        $display("[TB] run: restart from DONE, responses tied low");
        doRun(0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
